// File: rtl/io_pinmux_ctrl_pkg.sv
// Shared definitions for the IO pin multiplexer.
//   pad_state_e   : per-pad ownership state (driving vs tri-state guard)
//   GUARD_DEFAULT : default number of tri-state guard cycles on owner change
//   FUNC_*        : conventional function indices; function 0 is the reset owner
package io_pkg;

  typedef enum logic {
    PAD_ACTIVE = 1'b0,
    PAD_GUARD  = 1'b1
  } pad_state_e;

  localparam int GUARD_DEFAULT = 3;

  localparam int FUNC_GPIO = 0;
  localparam int FUNC_UART = 1;
  localparam int FUNC_SPI  = 2;
  localparam int FUNC_I2C  = 3;

endpackage

// File: rtl/io_pinmux_ctrl_pad_slot.sv
// One pad's ownership slot: owner select, guard FSM and counter, registered
// output mux, and a 2-flop input synchroniser routed back to the owner only.
//   i_clk, i_rst   : clock, synchronous active-high reset
//   i_c2p, i_oe    : output data / enable offered by each function
//   i_p2c          : asynchronous pad input
//   i_wr, i_wsel   : accepted config write for this pad and its new owner
//   o_c2p, o_en    : registered pad output data / enable
//   o_p2c          : synchronised pad input, one bit per function
//   o_busy, o_sel  : guard-in-progress flag, current owner
module io_pad_slot
  import io_pkg::*;
#(
  parameter int NFUNC = 4,
  parameter int GUARD = GUARD_DEFAULT,
  parameter int SW    = $clog2(NFUNC)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [NFUNC-1:0] i_c2p,
  input  logic [NFUNC-1:0] i_oe,
  input  logic             i_p2c,
  input  logic             i_wr,
  input  logic [SW-1:0]    i_wsel,
  output logic             o_c2p,
  output logic             o_en,
  output logic [NFUNC-1:0] o_p2c,
  output logic             o_busy,
  output logic [SW-1:0]    o_sel
);

  localparam int              GW    = (GUARD > 1) ? $clog2(GUARD) : 1;
  localparam logic [GW-1:0]   GLOAD = GW'(GUARD - 1);

  pad_state_e    r_state, w_state_nxt;
  logic [SW-1:0] r_sel, w_sel_nxt;
  logic [GW-1:0] r_gcnt, w_gcnt_nxt;
  logic          r_c2p, r_en, w_c2p_nxt, w_en_nxt;
  logic          r_sync1, r_sync2;
  logic          w_change;

  // NOTE: flops are written with non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= PAD_ACTIVE;
      r_sel   <= SW'(FUNC_GPIO);
      r_gcnt  <= '0;
      r_c2p   <= 1'b0;
      r_en    <= 1'b0;
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_sel   <= w_sel_nxt;
      r_gcnt  <= w_gcnt_nxt;
      r_c2p   <= w_c2p_nxt;
      r_en    <= w_en_nxt;
      r_sync1 <= i_p2c;
      r_sync2 <= r_sync1;
    end
  end

  // NOTE: every always_comb output is given a default first, so no path
  // through the case can leave a signal unassigned and infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_sel_nxt   = r_sel;
    w_gcnt_nxt  = r_gcnt;
    w_change    = i_wr && (i_wsel != r_sel);

    case (r_state)
      PAD_ACTIVE: begin
        if (w_change) begin
          w_state_nxt = PAD_GUARD;
          w_sel_nxt   = i_wsel;
          w_gcnt_nxt  = GLOAD;
        end
      end
      PAD_GUARD: begin
        // A new owner mid-guard restarts the full interval.
        if (w_change) begin
          w_sel_nxt  = i_wsel;
          w_gcnt_nxt = GLOAD;
        end else if (r_gcnt == '0) begin
          w_state_nxt = PAD_ACTIVE;
        end else begin
          w_gcnt_nxt = r_gcnt - GW'(1);
        end
      end
      default: w_state_nxt = PAD_ACTIVE;
    endcase

    // Outputs follow the next state, so the pad releases on the same edge
    // that accepts the write and the new owner drives on the edge leaving
    // the guard.
    w_c2p_nxt = 1'b0;
    w_en_nxt  = 1'b0;
    if (w_state_nxt == PAD_ACTIVE) begin
      w_c2p_nxt = i_c2p[w_sel_nxt];
      w_en_nxt  = i_oe[w_sel_nxt];
    end
  end

  always_comb begin
    o_p2c = '0;
    if (r_state == PAD_ACTIVE) o_p2c[r_sel] = r_sync2;
  end

  assign o_c2p  = r_c2p;
  assign o_en   = r_en;
  assign o_busy = (r_state == PAD_GUARD);
  assign o_sel  = r_sel;

endmodule

// File: rtl/io_pinmux_ctrl.sv
// Per-pad function arbiter for a bank of tri-state IO pads. Each pad is owned
// by one of NFUNC functions chosen by a config write; changing owner holds the
// pad tri-stated for GUARD cycles before the new owner may drive.
//   clk_i, rst_i                   : clock, synchronous active-high reset
//   cfg_we_i/addr_i/sel_i          : owner write (one per cycle)
//   cfg_err_o                      : one-cycle pulse after a rejected write
//   cfg_rd_addr_i / cfg_rd_sel_o   : combinational owner readback
//   busy_o                         : per-pad guard-in-progress flags
//   func_c2p_i/func_oe_i/func_p2c_o: per-function pad signals, index f*NPAD+i
//   pad_c2p_o/pad_c2p_en_o/pad_p2c_i: pad ring interface
module io_pinmux_ctrl
  import io_pkg::*;
#(
  parameter int NPAD  = 8,
  parameter int NFUNC = 4,
  parameter int GUARD = GUARD_DEFAULT,
  parameter int AW    = $clog2(NPAD),
  parameter int SW    = $clog2(NFUNC)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  cfg_we_i,
  input  logic [AW-1:0]         cfg_addr_i,
  input  logic [SW-1:0]         cfg_sel_i,
  output logic                  cfg_err_o,
  input  logic [AW-1:0]         cfg_rd_addr_i,
  output logic [SW-1:0]         cfg_rd_sel_o,
  output logic [NPAD-1:0]       busy_o,
  input  logic [NFUNC*NPAD-1:0] func_c2p_i,
  input  logic [NFUNC*NPAD-1:0] func_oe_i,
  output logic [NFUNC*NPAD-1:0] func_p2c_o,
  output logic [NPAD-1:0]       pad_c2p_o,
  output logic [NPAD-1:0]       pad_c2p_en_o,
  input  logic [NPAD-1:0]       pad_p2c_i
);

  logic                     w_addr_ok, w_sel_ok, w_wr_ok;
  logic                     r_err;
  logic [NPAD-1:0][SW-1:0]  w_sel;
  logic [SW-1:0]            w_sel_tab [2**AW];

  // With power-of-two NPAD/NFUNC these compares are always true and fold away.
  assign w_addr_ok = (int'(cfg_addr_i) < NPAD);
  assign w_sel_ok  = (int'(cfg_sel_i) < NFUNC);
  assign w_wr_ok   = cfg_we_i && w_addr_ok && w_sel_ok;

  always_ff @(posedge clk_i) begin
    if (rst_i) r_err <= 1'b0;
    else       r_err <= cfg_we_i && !(w_addr_ok && w_sel_ok);
  end

  assign cfg_err_o = r_err;

  for (genvar i = 0; i < NPAD; i++) begin : g_pad
    logic [NFUNC-1:0] w_c2p, w_oe, w_p2c;

    for (genvar f = 0; f < NFUNC; f++) begin : g_func
      assign w_c2p[f]               = func_c2p_i[f*NPAD+i];
      assign w_oe[f]                = func_oe_i[f*NPAD+i];
      assign func_p2c_o[f*NPAD+i]   = w_p2c[f];
    end

    io_pad_slot #(
      .NFUNC (NFUNC),
      .GUARD (GUARD),
      .SW    (SW)
    ) u_slot (
      .i_clk  (clk_i),
      .i_rst  (rst_i),
      .i_c2p  (w_c2p),
      .i_oe   (w_oe),
      .i_p2c  (pad_p2c_i[i]),
      .i_wr   (w_wr_ok && (cfg_addr_i == AW'(i))),
      .i_wsel (cfg_sel_i),
      .o_c2p  (pad_c2p_o[i]),
      .o_en   (pad_c2p_en_o[i]),
      .o_p2c  (w_p2c),
      .o_busy (busy_o[i]),
      .o_sel  (w_sel[i])
    );
  end

  // Readback table padded to the full address space; unused slots read 0.
  always_comb begin
    for (int k = 0; k < 2**AW; k++) w_sel_tab[k] = '0;
    for (int k = 0; k < NPAD; k++)  w_sel_tab[k] = w_sel[k];
  end

  assign cfg_rd_sel_o = w_sel_tab[cfg_rd_addr_i];

endmodule
